// File: rtl/ifetch_unit.sv
// Instruction fetch stage: fetches the opcode, then 0-2 operand bytes as sized by the decoder,
// and presents the instruction over valid/ready. Optional perf counters under FETCH_PERF_CNT_EN.
module ifetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  ir,
  input  logic [1:0]  dec_len,
  input  logic        dec_halt,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] operand,
  output logic [15:0] instr_pc,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] stall_count
`endif
);

  localparam logic [2:0] S_OP    = 3'd0;
  localparam logic [2:0] S_DEC   = 3'd1;
  localparam logic [2:0] S_B2    = 3'd2;
  localparam logic [2:0] S_B3    = 3'd3;
  localparam logic [2:0] S_VALID = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [15:0] operand_q, operand_d;
  logic [15:0] instr_pc_q, instr_pc_d;
  logic        rd_state;
  logic        xfer;

  assign rd_state    = (state_q == S_OP) || (state_q == S_B2) || (state_q == S_B3);
  // A redirect drops the request for its own cycle so any coincident ack has nothing to complete.
  assign mem_rd      = rd_state && !rst && !redirect;
  assign mem_addr    = pc_q;
  assign ir          = ir_q;
  assign operand     = operand_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = (state_q == S_VALID);
  assign xfer        = (state_q == S_VALID) && instr_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    operand_d  = operand_q;
    instr_pc_d = instr_pc_q;
    if (redirect) begin
      state_d = S_OP;
      pc_d    = redirect_pc;
    end else begin
      case (state_q)
        S_OP: begin
          if (mem_ack) begin
            ir_d       = mem_rdata;
            instr_pc_d = pc_q;
            operand_d  = 16'h0000;
            pc_d       = pc_q + 16'h0001;
            state_d    = S_DEC;
          end else begin
            state_d = S_OP;
          end
        end
        S_DEC: begin
          // Lengths 0 and 1 both mean opcode-only.
          if (dec_len[1]) begin
            state_d = S_B2;
          end else begin
            state_d = S_VALID;
          end
        end
        S_B2: begin
          if (mem_ack) begin
            operand_d[7:0] = mem_rdata;
            pc_d           = pc_q + 16'h0001;
            state_d        = (dec_len == 2'd3) ? S_B3 : S_VALID;
          end else begin
            state_d = S_B2;
          end
        end
        S_B3: begin
          if (mem_ack) begin
            operand_d[15:8] = mem_rdata;
            pc_d            = pc_q + 16'h0001;
            state_d         = S_VALID;
          end else begin
            state_d = S_B3;
          end
        end
        S_VALID: begin
          if (instr_ready) begin
            state_d = dec_halt ? S_HALT : S_OP;
          end else begin
            state_d = S_VALID;
          end
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_OP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_OP;
      pc_q       <= RESET_PC;
      ir_q       <= 8'h00;
      operand_q  <= 16'h0000;
      instr_pc_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      operand_q  <= operand_d;
      instr_pc_q <= instr_pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] stall_cnt_q;

  // A transfer still counts when a redirect lands in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 16'h0000;
      stall_cnt_q <= 16'h0000;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + {15'd0, xfer};
      stall_cnt_q <= stall_cnt_q + {15'd0, (mem_rd && !mem_ack)};
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule
